exception_sequencer: RTL and testbench

//   Multicycle exception controller for the MIPS core. Arbitrates the three exception sources
//   (invalid opcode, overflow, divide-by-zero) and saves EPC. Drives the select of the

---
 rtl/exc_pkg.sv | 21 ++
 rtl/exc_priority_enc.sv | 23 ++
 rtl/exception_sequencer.sv | 117 +++++++++++
 tb/tb_exception_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer: cause codes, FSM state encoding
// and the vector addresses the vector mux selects between.
package exc_pkg;

    localparam logic [1:0] CAUSE_OPCODE = 2'b00;
    localparam logic [1:0] CAUSE_OVF    = 2'b01;
    localparam logic [1:0] CAUSE_DIV0   = 2'b10;

    localparam logic [7:0] VEC_OPCODE = 8'd253;
    localparam logic [7:0] VEC_OVF    = 8'd254;
    localparam logic [7:0] VEC_DIV0   = 8'd255;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAVE,
        ST_FETCH,
        ST_LOAD,
        ST_DONE
    } exc_state_t;

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority encoder for the three exception sources: opcode > overflow > divzero.
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_divzero,
    output logic       valid,
    output logic [1:0] cause
);

    always_comb begin
        valid = exc_opcode | exc_overflow | exc_divzero;
        cause = CAUSE_OPCODE;
        if (exc_opcode)
            cause = CAUSE_OPCODE;
        else if (exc_overflow)
            cause = CAUSE_OVF;
        else if (exc_divzero)
            cause = CAUSE_DIV0;
    end

endmodule

// File: rtl/exception_sequencer.sv
// Multicycle exception controller: saves EPC, fetches the handler byte from the vector
// address and redirects PC. Optional EXC_CAUSE_REG_EN adds cause_out and lost_exc outputs.
module exception_sequencer
    import exc_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned EPC_OFFSET  = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_in,
    input  logic [7:0]  mem_data,
    output logic [1:0]  mux_sel,
    output logic        addr_sel,
    output logic        mem_read,
    output logic        epc_write,
    output logic [31:0] epc_data,
    output logic        pc_write,
    output logic [31:0] pc_data,
`ifdef EXC_CAUSE_REG_EN
    output logic [1:0]  cause_out,
    output logic [0:0]  lost_exc,
`endif
    output logic        busy,
    output logic        done
);

    exc_state_t state;
    logic [2:0] wait_cnt;
    logic       req_valid;
    logic [1:0] req_cause;

    exc_priority_enc u_prio (
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_divzero  (exc_divzero),
        .valid        (req_valid),
        .cause        (req_cause)
    );

    // All outputs are registered; each transition sets up the outputs of the next state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            wait_cnt  <= '0;
            mux_sel   <= CAUSE_OPCODE;
            addr_sel  <= 1'b0;
            mem_read  <= 1'b0;
            epc_write <= 1'b0;
            epc_data  <= '0;
            pc_write  <= 1'b0;
            pc_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef EXC_CAUSE_REG_EN
            cause_out <= CAUSE_OPCODE;
            lost_exc  <= 1'b0;
`endif
        end else begin
`ifdef EXC_CAUSE_REG_EN
            if (busy && req_valid)
                lost_exc <= 1'b1;
`endif
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        state     <= ST_SAVE;
                        mux_sel   <= req_cause;
                        epc_data  <= pc_in - 32'(EPC_OFFSET);
                        epc_write <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    state     <= ST_FETCH;
                    epc_write <= 1'b0;
                    addr_sel  <= 1'b1;
                    mem_read  <= 1'b1;
                    wait_cnt  <= 3'(MEM_LATENCY - 1);
`ifdef EXC_CAUSE_REG_EN
                    cause_out <= mux_sel;
`endif
                end
                ST_FETCH: begin
                    // The byte is captured on the last of MEM_LATENCY fetch cycles.
                    if (wait_cnt == 3'd0) begin
                        state    <= ST_LOAD;
                        addr_sel <= 1'b0;
                        mem_read <= 1'b0;
                        pc_data  <= {24'b0, mem_data};
                        pc_write <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_LOAD: begin
                    state    <= ST_DONE;
                    pc_write <= 1'b0;
                    done     <= 1'b1;
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    mux_sel <= CAUSE_OPCODE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Directed self-checking bench for exception_sequencer (MEM_LATENCY=1 and =3 instances).
// Build with EXC_CAUSE_REG_EN defined to also check cause_out / lost_exc.
module tb_exception_sequencer;
    import exc_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        exc_opcode, exc_overflow, exc_divzero;
    logic [31:0] pc_in;
    logic [7:0]  mem_data;
    logic [1:0]  mux_sel;
    logic        addr_sel, mem_read, epc_write, pc_write, busy, done;
    logic [31:0] epc_data, pc_data;

    logic        d3_opcode, d3_overflow, d3_divzero;
    logic [31:0] d3_pc_in;
    logic [7:0]  d3_mem_data;
    logic [1:0]  d3_mux_sel;
    logic        d3_addr_sel, d3_mem_read, d3_epc_write, d3_pc_write, d3_busy, d3_done;
    logic [31:0] d3_epc_data, d3_pc_data;
`ifdef EXC_CAUSE_REG_EN
    logic [1:0]  cause_out, d3_cause_out;
    logic [0:0]  lost_exc, d3_lost_exc;
`endif

    int checks = 0;
    int errors = 0;
    int pulses;

    always #5 clock = ~clock;

    exception_sequencer #(.MEM_LATENCY(1), .EPC_OFFSET(4)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_divzero  (exc_divzero),
        .pc_in        (pc_in),
        .mem_data     (mem_data),
        .mux_sel      (mux_sel),
        .addr_sel     (addr_sel),
        .mem_read     (mem_read),
        .epc_write    (epc_write),
        .epc_data     (epc_data),
        .pc_write     (pc_write),
        .pc_data      (pc_data),
`ifdef EXC_CAUSE_REG_EN
        .cause_out    (cause_out),
        .lost_exc     (lost_exc),
`endif
        .busy         (busy),
        .done         (done)
    );

    exception_sequencer #(.MEM_LATENCY(3), .EPC_OFFSET(4)) dut3 (
        .clock        (clock),
        .reset_n      (reset_n),
        .exc_opcode   (d3_opcode),
        .exc_overflow (d3_overflow),
        .exc_divzero  (d3_divzero),
        .pc_in        (d3_pc_in),
        .mem_data     (d3_mem_data),
        .mux_sel      (d3_mux_sel),
        .addr_sel     (d3_addr_sel),
        .mem_read     (d3_mem_read),
        .epc_write    (d3_epc_write),
        .epc_data     (d3_epc_data),
        .pc_write     (d3_pc_write),
        .pc_data      (d3_pc_data),
`ifdef EXC_CAUSE_REG_EN
        .cause_out    (d3_cause_out),
        .lost_exc     (d3_lost_exc),
`endif
        .busy         (d3_busy),
        .done         (d3_done)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_mux_sel"}, 32'(mux_sel), 32'd0);
        check_output({tag, "_addr_sel"}, 32'(addr_sel), 32'd0);
        check_output({tag, "_mem_read"}, 32'(mem_read), 32'd0);
        check_output({tag, "_epc_write"}, 32'(epc_write), 32'd0);
        check_output({tag, "_epc_data"}, epc_data, 32'd0);
        check_output({tag, "_pc_write"}, 32'(pc_write), 32'd0);
        check_output({tag, "_pc_data"}, pc_data, 32'd0);
        check_output({tag, "_busy"}, 32'(busy), 32'd0);
        check_output({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
        {d3_opcode, d3_overflow, d3_divzero} = 3'b000;
        pc_in = '0; mem_data = '0; d3_pc_in = '0; d3_mem_data = '0;
        tick();
        tick();
        $display("[TB] reset state");
        check_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Test 1: overflow, pc_in=0x40, mem_data=0x80
        $display("[TB] test 1: single overflow request");
        pc_in = 32'h40; mem_data = 8'h80; exc_overflow = 1'b1;
        tick();
        exc_overflow = 1'b0;
        check_output("t1_epc_write", 32'(epc_write), 32'd1);
        check_output("t1_epc_data", epc_data, 32'h3C);
        check_output("t1_busy_save", 32'(busy), 32'd1);
        tick();
        check_output("t1_mux_sel_fetch", 32'(mux_sel), 32'(CAUSE_OVF));
        check_output("t1_mem_read", 32'(mem_read), 32'd1);
        check_output("t1_addr_sel", 32'(addr_sel), 32'd1);
        check_output("t1_epc_write_low", 32'(epc_write), 32'd0);
        tick();
        check_output("t1_pc_write", 32'(pc_write), 32'd1);
        check_output("t1_pc_data", pc_data, 32'h80);
        check_output("t1_mem_read_low", 32'(mem_read), 32'd0);
        tick();
        check_output("t1_done", 32'(done), 32'd1);
        check_output("t1_pc_write_low", 32'(pc_write), 32'd0);
        check_output("t1_busy_done", 32'(busy), 32'd1);
        tick();
        check_output("t1_done_low", 32'(done), 32'd0);
        check_output("t1_busy_idle", 32'(busy), 32'd0);

        // Test 2: all three at once, opcode wins, single sequence
        $display("[TB] test 2: simultaneous requests");
        pc_in = 32'h100; mem_data = 8'h11;
        {exc_opcode, exc_overflow, exc_divzero} = 3'b111;
        tick();
        {exc_opcode, exc_overflow, exc_divzero} = 3'b000;
        check_output("t2_epc_data", epc_data, 32'hFC);
        tick();
        check_output("t2_mux_sel", 32'(mux_sel), 32'(CAUSE_OPCODE));
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (epc_write) pulses++;
        end
        check_output("t2_extra_epc_write", 32'(pulses), 32'd0);
        check_output("t2_busy_end", 32'(busy), 32'd0);

        // Test 3: divzero re-asserted during FETCH is ignored
        $display("[TB] test 3: request during FETCH");
        pc_in = 32'h200; mem_data = 8'h22; exc_divzero = 1'b1;
        tick();
        exc_divzero = 1'b0;
        tick();
        check_output("t3_mux_sel", 32'(mux_sel), 32'(CAUSE_DIV0));
        exc_divzero = 1'b1;
        tick();
        exc_divzero = 1'b0;
        check_output("t3_pc_data", pc_data, 32'h22);
        tick();
        check_output("t3_done", 32'(done), 32'd1);
        tick();
        tick();
        check_output("t3_no_restart_epc", 32'(epc_write), 32'd0);
        check_output("t3_no_restart_busy", 32'(busy), 32'd0);
`ifdef EXC_CAUSE_REG_EN
        check_output("t3_lost_exc", 32'(lost_exc), 32'd1);
        check_output("t3_cause_out", 32'(cause_out), 32'(CAUSE_DIV0));
`endif

        // Test 4: reset during FETCH aborts the sequence
        $display("[TB] test 4: reset mid-sequence");
        pc_in = 32'h300; mem_data = 8'h33; exc_opcode = 1'b1;
        tick();
        exc_opcode = 1'b0;
        tick();
        check_output("t4_mem_read_pre", 32'(mem_read), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_all_zero("t4_after_reset");
`ifdef EXC_CAUSE_REG_EN
        check_output("t4_lost_exc", 32'(lost_exc), 32'd0);
        check_output("t4_cause_out", 32'(cause_out), 32'd0);
`endif
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pc_write) pulses++;
        end
        check_output("t4_no_pc_write", 32'(pulses), 32'd0);

        // Test 5: MEM_LATENCY=3 instance with wrapping EPC
        $display("[TB] test 5: latency 3, EPC wrap");
        d3_pc_in = 32'h2; d3_mem_data = 8'h55; d3_overflow = 1'b1;
        tick();
        d3_overflow = 1'b0;
        check_output("t5_epc_write", 32'(d3_epc_write), 32'd1);
        check_output("t5_epc_data", d3_epc_data, 32'hFFFF_FFFE);
        for (int c = 2; c <= 4; c++) begin
            tick();
            check_output($sformatf("t5_pc_write_early_c%0d", c), 32'(d3_pc_write), 32'd0);
        end
        tick();
        check_output("t5_pc_write_c5", 32'(d3_pc_write), 32'd1);
        check_output("t5_pc_data", d3_pc_data, 32'h55);
        tick();
        check_output("t5_done_c6", 32'(d3_done), 32'd1);
        tick();
        check_output("t5_busy_idle", 32'(d3_busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
